// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU unit beside the EX-stage ALU.
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle,
// with sign fix-up in a final cycle. Divide-by-zero and signed overflow resolve
// at the start edge. stall_ holds the front of the pipeline until done_.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_,
    input  logic [2:0]      funct3_,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic            flush_,
    output logic            stall_,
    output logic            busy_,
    output logic            done_,
    output logic [XLEN-1:0] result_
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic            accept;
    logic            op_signed;
    logic            op_rem;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            last_iter;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // Two's-complement magnitude of a value, only when it is treated as signed.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        magnitude = (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    // Conditional negation used for the final sign correction.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        cond_neg = neg ? (~v + 1'b1) : v;
    endfunction

    // Operation decode and special-case detection on the request inputs.
    always_comb begin
        accept    = (state_q == S_IDLE) && start_ && !flush_;
        op_signed = (funct3_ == 3'b100) || (funct3_ == 3'b110);
        op_rem    = (funct3_ == 3'b110) || (funct3_ == 3'b111);
        div_zero  = (rs2_value == '0);
        ovf       = op_signed && (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_value == '1);
        special   = div_zero || ovf;
        // Overflow quotient equals the dividend itself (most negative value).
        if (div_zero)
            special_res = op_rem ? rs1_value : '1;
        else
            special_res = op_rem ? '0 : rs1_value;
        last_iter = (cnt_q == CNT_W'(XLEN-1));
        // Shift the next dividend bit (quotient MSB) into the partial remainder.
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvsr_q};
        fits      = !diff[XLEN];
    end

    // State register; reset aborts any operation without a done_ pulse.
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; flush_ cancels CALC/FIX but not the DONE pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_)
                    state_d = S_IDLE;
                else if (last_iter)
                    state_d = S_FIX;
            end
            S_FIX:  state_d = flush_ ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; stall_ also covers the accepting cycle.
    always_comb begin
        stall_ = 1'b0;
        busy_  = 1'b0;
        done_  = 1'b0;
        case (state_q)
            S_IDLE: stall_ = start_ && !flush_;
            S_CALC: begin stall_ = 1'b1; busy_ = 1'b1; end
            S_FIX:  begin stall_ = 1'b1; busy_ = 1'b1; end
            S_DONE: begin busy_ = 1'b1; done_ = 1'b1; end
            default: ;
        endcase
    end

    // Datapath next values: operand latch, restoring iteration, sign fix-up.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = magnitude(rs1_value, op_signed);
                    dvsr_d    = magnitude(rs2_value, op_signed);
                    is_rem_d  = op_rem;
                    neg_quo_d = op_signed && (rs1_value[XLEN-1] ^ rs2_value[XLEN-1]);
                    neg_rem_d = op_signed && rs1_value[XLEN-1];
                    if (special)
                        result_d = special_res;
                end
            end
            S_CALC: begin
                if (!flush_) begin
                    rem_d = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], fits};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (!flush_)
                    result_d = is_rem_q ? cond_neg(rem_q, neg_rem_q) : cond_neg(quo_q, neg_quo_q);
            end
            default: ;
        endcase
    end

    // Datapath registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign result_ = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: directed and random RV32M divide operations,
// expected results and done_ cycles queued at issue, checked by a monitor.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_;
    logic [2:0]  funct3_;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        flush_;
    logic        stall_;
    logic        busy_;
    logic        done_;
    logic [31:0] result_;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_exp;

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_    (start_),
        .funct3_   (funct3_),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .flush_    (flush_),
        .stall_    (stall_),
        .busy_     (busy_),
        .done_     (done_),
        .result_   (result_)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        bit is_rem, is_sgn;
        is_rem = (f3 == 3'd6) || (f3 == 3'd7);
        is_sgn = (f3 == 3'd4) || (f3 == 3'd6);
        sa = a;
        sb = b;
        if (b == 32'd0)
            return is_rem ? a : 32'hFFFF_FFFF;
        if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_sgn)
            return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit is_sgn;
        is_sgn = (f3 == 3'd4) || (f3 == 3'd6);
        return (b == 32'd0) || (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: per-cycle busy_/stall_ and scoreboard pop on done_.
    always @(negedge clk) begin
        if (mon_en) begin
            bit pending;
            bit exp_stall;
            pending   = (sb_q.size() != 0);
            exp_stall = (pending && cyc < sb_q[0].cyc) || (!pending && start_ && !flush_);
            chk("busy", {31'd0, busy_}, {31'd0, pending});
            chk("stall", {31'd0, stall_}, {31'd0, exp_stall});
            if (done_ === 1'b1) begin
                if (!pending) begin
                    chk("unexpected_done", {31'd0, done_}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("result", result_, e.res);
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (pending && cyc >= sb_q[0].cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("missing_done", {31'd0, done_}, 32'd1);
            end
        end
    end

    // Issue one request; returns aligned #1 after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] exp_res);
        exp_t e;
        start_    = 1'b1;
        funct3_   = f3;
        rs1_value = a;
        rs2_value = b;
        @(posedge clk);
        #1;
        exp_res = ref_result(f3, a, b);
        e.res   = exp_res;
        e.cyc   = cyc + (is_special(f3, a, b) ? 0 : 33);
        sb_q.push_back(e);
        start_    = 1'b0;
        rs1_value = $urandom;
        rs2_value = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done_ pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        issue(f3, a, b, r);
        wait_idle();
        last_exp = r;
    endtask

    // Pulse flush_ in the cycle n edges after acceptance; kill says it cancels.
    task automatic flush_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input int n, input bit kill);
        logic [31:0] r;
        issue(f3, a, b, r);
        repeat (n) @(posedge clk);
        #1;
        flush_ = 1'b1;
        @(posedge clk);
        #1;
        flush_ = 1'b0;
        if (kill) begin
            if (sb_q.size() != 0) void'(sb_q.pop_back());
            chk("flush_result_held", result_, last_exp);
            chk("flush_no_busy", {31'd0, busy_}, 32'd0);
        end else begin
            wait_idle();
            last_exp = r;
        end
    endtask

    initial begin
        logic [31:0] r;
        rst       = 1'b0;
        start_    = 1'b0;
        flush_    = 1'b0;
        funct3_   = 3'd5;
        rs1_value = '0;
        rs2_value = '0;
        last_exp  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_result", result_, 32'd0);
        chk("reset_done", {31'd0, done_}, 32'd0);
        chk("reset_busy", {31'd0, busy_}, 32'd0);
        chk("reset_stall", {31'd0, stall_}, 32'd0);
        mon_en = 1'b1;

        // Directed cases
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'd5, 32'd0);
        run_op(3'd7, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd7, 32'hFFFF_FFFF, 32'd10);

        // Flush in CALC (iteration 10), in FIX, and in DONE
        flush_op(3'd5, 32'd1000, 32'd10, 10, 1'b1);
        run_op(3'd5, 32'd9, 32'd3);
        flush_op(3'd4, 32'hFFFF_0000, 32'd3, 32, 1'b1);
        flush_op(3'd6, 32'd77, 32'hFFFF_FFF6, 33, 1'b0);

        // flush_ beats start_ in IDLE
        start_  = 1'b1;
        flush_  = 1'b1;
        funct3_ = 3'd5;
        rs1_value = 32'd50;
        rs2_value = 32'd5;
        @(posedge clk);
        #1;
        start_ = 1'b0;
        flush_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_blocks_start", result_, last_exp);

        // Reset during CALC
        issue(3'd5, 32'd12345, 32'd17, r);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        chk("midreset_result", result_, 32'd0);
        chk("midreset_done", {31'd0, done_}, 32'd0);
        chk("midreset_busy", {31'd0, busy_}, 32'd0);
        chk("midreset_stall", {31'd0, stall_}, 32'd0);
        last_exp = '0;
        repeat (40) @(posedge clk);
        #1;

        // start_ raised during DONE is ignored
        issue(3'd5, 32'd81, 32'd9, r);
        repeat (33) @(posedge clk);
        #1;
        start_    = 1'b1;
        funct3_   = 3'd5;
        rs1_value = 32'd64;
        rs2_value = 32'd8;
        @(posedge clk);
        #1;
        start_ = 1'b0;
        last_exp = r;
        repeat (40) @(posedge clk);
        #1;
        chk("done_start_ignored", result_, 32'd9);
        run_op(3'd5, 32'd64, 32'd8);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [2:0]  f3;
            int          sel;
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
            if (sel == 3) b = -($urandom_range(1, 50));
            run_op(f3, a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%0d required=0", sb_q.size());
        end
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
